axi_infer_master: RTL and testbench

- Parametrised AXI4 master that launches one inference transaction on the wafer-defect accelerator.
- Buffers NUM_WORDS instruction/feature words from a valid/ready stream and writes them as a single INCR burst to WR_BASE.
- Then reads the result beat from RD_BASE and returns a PRED_W-bit class prediction.
- Successor to the single-beat SoC bring-up master: adds multi-beat bursts, B/R response checking, a timeout, and return-to-idle for repeated inferences.

---
 rtl/axi_infer_master.sv | 213 +++++++++++++++++++++
 tb/tb_axi_infer_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_infer_master.sv
// AXI4 inference master for the wafer-defect accelerator.
// It collects NUM_WORDS input words and writes them as one INCR burst.
// It then reads one result beat and returns a PRED_W-bit class prediction.
// Every AXI wait state has a bounded timeout.
module axi_infer_master #(
  parameter int unsigned          ADDR_W    = 64,
  parameter int unsigned          DATA_W    = 128,
  parameter int unsigned          ID_W      = 12,
  parameter int unsigned          TXN_ID    = 0,
  parameter int unsigned          NUM_WORDS = 4,
  parameter logic [ADDR_W-1:0]    WR_BASE   = '0,
  parameter logic [ADDR_W-1:0]    RD_BASE   = ADDR_W'(64'h1000),
  parameter int unsigned          PRED_W    = 4,
  parameter int unsigned          TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [PRED_W-1:0]   prediction,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0]      SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [ID_W-1:0] TID  = ID_W'(TXN_ID);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_BRESP, S_AR, S_RDATA, S_FIN
  } state_t;

  state_t state, state_d;

  logic [NUM_WORDS-1:0][DATA_W-1:0] wbuf;
  logic [CW-1:0] cnt, beat;
  logic [TW-1:0] tmo;
  logic          aw_vld, w_vld;
  logic          ec_set, pred_set;
  logic [1:0]    ec_d;
  logic          in_fire, aw_fire, w_fire, w_last, tmo_hit;

  assign in_ready = (state == S_LOAD) && (cnt < CW'(NUM_WORDS));
  assign in_fire  = in_valid && in_ready;
  assign w_last   = (beat == CW'(NUM_WORDS - 1));
  assign aw_fire  = aw_vld && m_axi_awready;
  assign w_fire   = w_vld && m_axi_wready;
  assign tmo_hit  = (tmo == TW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state plus error-code and prediction capture requests.
  always_comb begin
    state_d  = state;
    ec_set   = 1'b0;
    ec_d     = 2'd0;
    pred_set = 1'b0;
    case (state)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (in_fire && cnt == CW'(NUM_WORDS - 1)) state_d = S_WRITE;
      S_WRITE: begin
        if ((!aw_vld || aw_fire) && (!w_vld || (w_fire && w_last))) begin
          state_d = S_BRESP;
        end else if (tmo_hit && !aw_fire && !w_fire) begin
          state_d = S_FIN; ec_set = 1'b1; ec_d = 2'd3;
        end
      end
      S_BRESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00 || m_axi_bid != TID) begin
            state_d = S_FIN; ec_set = 1'b1; ec_d = 2'd1;
          end else begin
            state_d = S_AR;
          end
        end else if (tmo_hit) begin
          state_d = S_FIN; ec_set = 1'b1; ec_d = 2'd3;
        end
      end
      S_AR: begin
        if (m_axi_arready) state_d = S_RDATA;
        else if (tmo_hit) begin
          state_d = S_FIN; ec_set = 1'b1; ec_d = 2'd3;
        end
      end
      S_RDATA: begin
        if (m_axi_rvalid && (m_axi_rresp != 2'b00 || m_axi_rid != TID)) begin
          state_d = S_FIN; ec_set = 1'b1; ec_d = 2'd2;
        end else if (m_axi_rvalid && m_axi_rlast) begin
          state_d = S_FIN; pred_set = 1'b1;
        end else if (tmo_hit && !m_axi_rvalid) begin
          state_d = S_FIN; ec_set = 1'b1; ec_d = 2'd3;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: word buffer, beat and word counters, AW/W valids, result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbuf       <= '0;
      cnt        <= '0;
      beat       <= '0;
      aw_vld     <= 1'b0;
      w_vld      <= 1'b0;
      err_code   <= 2'd0;
      prediction <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        cnt      <= '0;
        beat     <= '0;
        err_code <= 2'd0;
      end
      if (in_fire) begin
        wbuf[cnt[IW-1:0]] <= in_data;
        cnt               <= cnt + 1'b1;
      end
      if (state == S_LOAD && state_d == S_WRITE) begin
        aw_vld <= 1'b1;
        w_vld  <= 1'b1;
        beat   <= '0;
      end
      if (state == S_WRITE) begin
        if (aw_fire) aw_vld <= 1'b0;
        if (w_fire) begin
          beat <= beat + 1'b1;
          if (w_last) w_vld <= 1'b0;
        end
        // A timeout abandons whatever is still outstanding.
        if (state_d == S_FIN) begin
          aw_vld <= 1'b0;
          w_vld  <= 1'b0;
        end
      end
      if (ec_set)   err_code   <= ec_d;
      if (pred_set) prediction <= m_axi_rdata[PRED_W-1:0];
    end
  end

  // Wait-state timer: restarts on every state change and on any WRITE handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo <= '0;
    else if (state_d != state || (state == S_WRITE && (aw_fire || w_fire))) tmo <= '0;
    else if (state == S_WRITE || state == S_BRESP || state == S_AR || state == S_RDATA)
      tmo <= tmo + 1'b1;
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);
  assign err  = done && (err_code != 2'd0);

  assign m_axi_awid    = TID;
  assign m_axi_awaddr  = aw_vld ? WR_BASE : '0;
  assign m_axi_awlen   = aw_vld ? 8'(NUM_WORDS - 1) : 8'd0;
  assign m_axi_awsize  = SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = aw_vld;

  assign m_axi_wdata   = w_vld ? wbuf[beat[IW-1:0]] : '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = w_vld && w_last;
  assign m_axi_wvalid  = w_vld;

  assign m_axi_bready  = (state == S_BRESP);

  assign m_axi_arid    = TID;
  assign m_axi_arvalid = (state == S_AR);
  assign m_axi_araddr  = m_axi_arvalid ? RD_BASE : '0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = SIZE;
  assign m_axi_arburst = 2'b01;

  assign m_axi_rready  = (state == S_RDATA);
endmodule

// File: tb/tb_axi_infer_master.sv
// Scoreboard bench for axi_infer_master.
// dut uses 4 words with a short timeout.
// dut1 uses a single word and exercises reset in the middle of a write.
module tb_axi_infer_master;
  localparam int NW = 4;

  logic clk = 1'b0, rst = 1'b1, rst1 = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- main DUT ----------------
  logic start = 0, in_valid = 0, in_ready, busy, done, err;
  logic [127:0] in_data = '0;
  logic [1:0] err_code; logic [3:0] prediction;
  logic [11:0] awid, bid, arid, rid;
  logic [63:0] awaddr, araddr;
  logic [7:0] awlen, arlen; logic [2:0] awsize, arsize; logic [1:0] awburst, arburst;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready, arvalid, arready;
  logic rvalid, rready, rlast;
  logic [127:0] wdata, rdata; logic [15:0] wstrb; logic [1:0] bresp, rresp;

  axi_infer_master #(.NUM_WORDS(NW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .prediction(prediction),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rid(rid), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready));

  // slave model knobs and state
  int aw_delay = 0, aw_wait;
  bit wtog = 0, b_en = 1, tog, b_pend, r_pend;
  logic [1:0] b_resp_k = 2'b00;
  logic [11:0] r_id_k = '0;
  logic [127:0] r_data_k = '0;

  assign awready = (aw_wait >= aw_delay);
  assign wready  = wtog ? tog : 1'b1;
  assign bvalid  = b_en && b_pend;
  assign bresp   = b_resp_k;
  assign bid     = '0;
  assign arready = 1'b1;
  assign rvalid  = r_pend;
  assign rdata   = r_data_k;
  assign rid     = r_id_k;
  assign rresp   = 2'b00;
  assign rlast   = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_wait <= 0; tog <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      tog <= ~tog;
      if (wvalid && wready && wlast) b_pend <= 1'b1;
      else if (bvalid && bready)     b_pend <= 1'b0;
      if (arvalid && arready)        r_pend <= 1'b1;
      else if (rvalid && rready)     r_pend <= 1'b0;
    end
  end

  // scoreboard
  logic [127:0] wq[$];
  logic [6:0]   rq[$];
  int aw_stall = 0, wbeat = 0, ar_cnt = 0, done_cnt = 0, b_cyc = 0, d_cyc = 0;
  bit bready_q = 0;

  always @(negedge clk) if (!rst) begin
    if (awvalid && !awready) aw_stall++;
    if (awvalid && awready)
      chk("aw_fields", {awid, awaddr, awlen, awsize, awburst},
          {12'h0, 64'h0, 8'd3, 3'd4, 2'b01});
    if (wvalid && wready) begin
      if (wq.size() == 0) chk("w_extra", 1, 0);
      else chk("wdata", wdata, wq.pop_front());
      chk("wlast", {wstrb, wlast}, {16'hffff, wbeat == NW - 1});
      wbeat++;
    end
    if (arvalid && arready) begin
      ar_cnt++;
      chk("ar_fields", {arid, arlen, arsize, arburst, araddr},
          {12'h0, 8'd0, 3'd4, 2'b01, 64'h1000});
    end
    if (bready && !bready_q) b_cyc = cyc;
    bready_q = bready;
    if (done) begin
      d_cyc = cyc;
      done_cnt++;
      if (rq.size() == 0) chk("done_extra", 1, 0);
      else chk("result", {prediction, err_code, err}, rq.pop_front());
    end
  end

  // ---------------- single-word DUT ----------------
  logic start1 = 0, in_valid1 = 0, in_ready1, busy1, done1, err1, en1 = 0;
  logic [127:0] in_data1 = '0, wdata1, w1_exp = '0;
  logic [1:0] err_code1; logic [3:0] prediction1;
  logic [11:0] awid1, arid1;
  logic [63:0] awaddr1, araddr1;
  logic [7:0] awlen1, arlen1; logic [2:0] awsize1, arsize1; logic [1:0] awburst1, arburst1;
  logic awvalid1, wvalid1, wlast1, bready1, arvalid1, rready1;
  logic [15:0] wstrb1;
  int w1_beats = 0, done1_cnt = 0;

  axi_infer_master #(.NUM_WORDS(1), .TIMEOUT(16)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .busy(busy1), .done(done1), .err(err1), .err_code(err_code1),
    .prediction(prediction1),
    .m_axi_awid(awid1), .m_axi_awaddr(awaddr1), .m_axi_awlen(awlen1), .m_axi_awsize(awsize1),
    .m_axi_awburst(awburst1), .m_axi_awvalid(awvalid1), .m_axi_awready(en1),
    .m_axi_wdata(wdata1), .m_axi_wstrb(wstrb1), .m_axi_wlast(wlast1), .m_axi_wvalid(wvalid1),
    .m_axi_wready(en1), .m_axi_bid(12'h0), .m_axi_bresp(2'b00), .m_axi_bvalid(1'b1),
    .m_axi_bready(bready1), .m_axi_arid(arid1), .m_axi_araddr(araddr1), .m_axi_arlen(arlen1),
    .m_axi_arsize(arsize1), .m_axi_arburst(arburst1), .m_axi_arvalid(arvalid1),
    .m_axi_arready(1'b1), .m_axi_rdata(128'h5), .m_axi_rid(12'h0), .m_axi_rresp(2'b00),
    .m_axi_rlast(1'b1), .m_axi_rvalid(1'b1), .m_axi_rready(rready1));

  always @(negedge clk) if (!rst1) begin
    if (wvalid1 && en1) begin
      w1_beats++;
      chk("w1_beat", {wlast1, wdata1}, {1'b1, w1_exp});
    end
    if (done1) begin
      done1_cnt++;
      chk("w1_result", {prediction1, err_code1, err1}, {4'h5, 2'd0, 1'b0});
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk_reset(input string tag);
    chk(tag, {awvalid, wvalid, bready, arvalid, rready, in_ready, busy, done, err,
              err_code, prediction, awlen}, '0);
    chk({tag, "_bus"}, {awaddr, araddr}, '0);
  endtask

  task automatic run(input logic [127:0] w0, input logic [6:0] exp_res);
    int n, d0;
    for (int i = 0; i < NW; i++) wq.push_back(w0 + 128'(i));
    rq.push_back(exp_res);
    wbeat = 0; aw_stall = 0; d0 = done_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1; in_data = w0 + 128'(i);
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 300) begin @(negedge clk); n++; end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    chk("beats", wbeat, NW);
    chk("wq_empty", wq.size(), 0);
    wq.delete();
    @(negedge clk); @(negedge clk);
    chk("idle", busy, 0);
  endtask

  logic [3:0] pred_m;
  int ar0, n;

  initial begin
    pred_m = 4'h0;
    #1 chk_reset("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    // 1: clean burst
    r_data_k = 128'h7;
    run(128'h1, {4'h7, 2'd0, 1'b0}); pred_m = 4'h7;

    // 2: slow AW and toggling W ready
    aw_delay = 5; wtog = 1; r_data_k = 128'h9;
    run(128'h100, {4'h9, 2'd0, 1'b0}); pred_m = 4'h9;
    chk("aw_stall", aw_stall, 5);
    aw_delay = 0; wtog = 0;

    // 3: B error, no read issued
    b_resp_k = 2'b10; r_data_k = 128'hf; ar0 = ar_cnt;
    run(128'h200, {pred_m, 2'd1, 1'b1});
    chk("no_ar", ar_cnt, ar0);
    b_resp_k = 2'b00;

    // 4: R id error, then clean run
    r_id_k = 12'h5;
    run(128'h300, {pred_m, 2'd2, 1'b1});
    r_id_k = 12'h0; r_data_k = 128'ha;
    run(128'h400, {4'ha, 2'd0, 1'b0}); pred_m = 4'ha;

    // 5: B never arrives -> timeout
    b_en = 0;
    run(128'h500, {pred_m, 2'd3, 1'b1});
    chk("tmo_lat", d_cyc - b_cyc, 16);
    @(negedge clk) rst = 1'b1;
    #1 chk_reset("reset2");
    @(negedge clk) rst = 1'b0;
    b_en = 1;

    // 6: single word, reset mid-WRITE, then clean single beat
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0; in_valid1 = 1'b1; in_data1 = 128'hab;
    @(negedge clk) in_valid1 = 1'b0;
    n = 0;
    while (!awvalid1 && n < 20) begin @(negedge clk); n++; end
    chk("w1_stuck", {awvalid1, wvalid1, busy1}, 3'b111);
    rst1 = 1'b1;
    #1 chk("w1_rst_mid", {awvalid1, wvalid1, busy1, done1}, 4'b0);
    @(negedge clk) rst1 = 1'b0;
    chk("w1_no_done", done1_cnt, 0);
    en1 = 1'b1; w1_exp = 128'hcd; w1_beats = 0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0; in_valid1 = 1'b1; in_data1 = 128'hcd;
    @(negedge clk) in_valid1 = 1'b0;
    n = 0;
    while (done1_cnt == 0 && n < 100) begin @(negedge clk); n++; end
    chk("w1_done", done1_cnt, 1);
    chk("w1_beats", w1_beats, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
